// File: rtl/arst_req_ctrl.sv
// arst_req_ctrl: reset-request initiator with minimum hold, ack timeouts, error flag and completion counter
module arst_req_ctrl #(
  parameter int SYNC_STAGES     = 2,
  parameter int HOLD_CYCLES     = 16,
  parameter int ACK_TIMEOUT     = 64,
  parameter int COOLDOWN_CYCLES = 8,
  parameter int CNT_W           = 8
) (
  input  logic             ref_clk_i,
  input  logic             srst_i,
  input  logic             sw_req_i,
  input  logic             wdt_req_i,
  input  logic             clr_err_i,
  input  logic             arst_n_i,
  output logic             arst_req_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             timeout_o,
  output logic             err_o,
  output logic [CNT_W-1:0] req_count_o
);
  localparam int TM1  = ACK_TIMEOUT > HOLD_CYCLES ? ACK_TIMEOUT : HOLD_CYCLES;
  localparam int TMAX = TM1 > COOLDOWN_CYCLES ? TM1 : COOLDOWN_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);
  typedef enum logic [2:0] {IDLE, ASSERT, HOLD, RELEASE, COOLDOWN} state_t;
  state_t                 state, state_d;
  logic [TW-1:0]          timer, timer_d;
  logic [SYNC_STAGES-1:0] sync;
  logic [CNT_W-1:0]       cnt_d;
  logic                   sw_q, wdt_q, pend, pend_d, req_d, done_d, to_d, err_d, ack_n, evt;
  assign ack_n  = sync[SYNC_STAGES-1];
  assign evt    = (sw_req_i & ~sw_q) | (wdt_req_i & ~wdt_q);
  assign busy_o = state != IDLE;
  always_ff @(posedge ref_clk_i)
    if (srst_i) begin
      state       <= IDLE;
      timer       <= '0;
      sync        <= '1;
      sw_q        <= 1'b0;
      wdt_q       <= 1'b0;
      pend        <= 1'b0;
      arst_req_o  <= 1'b0;
      done_o      <= 1'b0;
      timeout_o   <= 1'b0;
      err_o       <= 1'b0;
      req_count_o <= '0;
    end else begin
      state       <= state_d;
      timer       <= timer_d;
      sync        <= {sync[SYNC_STAGES-2:0], arst_n_i};
      sw_q        <= sw_req_i;
      wdt_q       <= wdt_req_i;
      pend        <= pend_d;
      arst_req_o  <= req_d;
      done_o      <= done_d;
      timeout_o   <= to_d;
      err_o       <= err_d;
      req_count_o <= cnt_d;
    end
  always_comb begin
    state_d = state;
    timer_d = timer + TW'(1);
    req_d   = arst_req_o;
    done_d  = 1'b0;
    to_d    = 1'b0;
    pend_d  = pend | (evt & busy_o);
    cnt_d   = req_count_o;
    case (state)
      IDLE: begin
        timer_d = '0;
        if (evt | pend) begin
          state_d = ASSERT;
          req_d   = 1'b1;
          pend_d  = 1'b0;
        end
      end
      ASSERT:
        if (!ack_n) begin
          state_d = HOLD;
          timer_d = '0;
        end else if (timer == TW'(ACK_TIMEOUT - 1)) begin
          state_d = COOLDOWN;
          timer_d = '0;
          to_d    = 1'b1;
          req_d   = 1'b0;
        end
      HOLD:
        if (timer == TW'(HOLD_CYCLES - 1)) begin
          state_d = RELEASE;
          timer_d = '0;
          req_d   = 1'b0;
        end
      RELEASE:
        if (ack_n) begin
          state_d = COOLDOWN;
          timer_d = '0;
          done_d  = 1'b1;
          cnt_d   = &req_count_o ? req_count_o : req_count_o + CNT_W'(1);
        end else if (timer == TW'(ACK_TIMEOUT - 1)) begin
          state_d = COOLDOWN;
          timer_d = '0;
          to_d    = 1'b1;
        end
      COOLDOWN:
        if (timer == TW'(COOLDOWN_CYCLES - 1)) begin
          state_d = IDLE;
          timer_d = '0;
        end
      default: begin
        state_d = IDLE;
        timer_d = '0;
        req_d   = 1'b0;
      end
    endcase
    err_d = to_d | (err_o & ~clr_err_i);
  end
endmodule

// File: tb/tb_arst_req_ctrl.sv
// tb_arst_req_ctrl: scoreboard bench for arst_req_ctrl with a 3-cycle arst_no latency model
module tb_arst_req_ctrl;
  logic       clk = 1'b0, srst = 1'b1, sw = 1'b0, wdt = 1'b0, clr = 1'b0, arst_n = 1'b1;
  logic       req, busy, done, tmo, err;
  logic [1:0] cnt;
  int         cyc = 0, checks = 0, errors = 0, mode = 0, dly = 0, run = 0, last_len = 0;
  typedef struct {bit to; int cyc; int cnt; bit err; int len;} exp_t;
  exp_t sb[$];
  exp_t e;
  arst_req_ctrl #(.CNT_W(2)) dut (
    .ref_clk_i(clk), .srst_i(srst), .sw_req_i(sw), .wdt_req_i(wdt), .clr_err_i(clr),
    .arst_n_i(arst_n), .arst_req_o(req), .busy_o(busy), .done_o(done), .timeout_o(tmo),
    .err_o(err), .req_count_o(cnt)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
    end
  endtask
  always @(negedge clk)
    if (mode == 1) begin
      arst_n = 1'b1;
      dly = 0;
    end else if (arst_n != !req && !(mode == 2 && !arst_n)) begin
      dly++;
      if (dly == 3) begin
        arst_n = !req;
        dly = 0;
      end
    end else dly = 0;
  always @(negedge clk) begin
    if (req) run++;
    else if (run > 0) begin
      last_len = run;
      run = 0;
    end
    if (done | tmo) begin
      if (sb.size() == 0) chk("unexpected_pulse", {done, tmo}, 0);
      else begin
        e = sb.pop_front();
        chk("pulse_kind", {done, tmo}, e.to ? 1 : 2);
        chk("pulse_cycle", cyc, e.cyc);
        chk("req_count", cnt, e.cnt);
        chk("err", err, e.err);
        chk("req_high_len", last_len, e.len);
      end
    end
  end
  task automatic step();
    @(negedge clk);
  endtask
  task automatic upto(input int c);
    while (cyc < c) @(negedge clk);
  endtask
  task automatic do_reset();
    srst = 1'b1;
    step();
    srst = 1'b0;
  endtask
  task automatic request(input bit s, input bit w, output int t0);
    sw = s;
    wdt = w;
    t0 = cyc + 1;
    step();
    sw = 1'b0;
    wdt = 1'b0;
  endtask
  task automatic push_exp(input bit to, input int c, input int n, input bit er, input int len);
    sb.push_back('{to, c, n, er, len});
  endtask
  initial begin
    int t0, t1;
    int offs[3] = '{20, 25, 30};
    step();
    do_reset();
    chk("rst_req", req, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_timeout", tmo, 0);
    chk("rst_err", err, 0);
    chk("rst_count", cnt, 0);
    step();
    step();
    request(1, 0, t0);
    push_exp(0, t0 + 26, 1, 0, 21);
    chk("req_rise", req, 1);
    upto(t0 + 33);
    chk("busy_cooldown", busy, 1);
    step();
    chk("busy_idle", busy, 0);
    do_reset();
    step();
    request(1, 0, t0);
    push_exp(0, t0 + 26, 1, 0, 21);
    push_exp(0, t0 + 61, 2, 0, 21);
    foreach (offs[i]) begin
      upto(t0 + offs[i] - 1);
      wdt = 1'b1;
      step();
      wdt = 1'b0;
    end
    upto(t0 + 75);
    chk("collapse_idle", busy, 0);
    chk("collapse_count", cnt, 2);
    do_reset();
    step();
    request(1, 1, t0);
    push_exp(0, t0 + 26, 1, 0, 21);
    upto(t0 + 45);
    chk("simul_idle", busy, 0);
    chk("simul_count", cnt, 1);
    do_reset();
    mode = 1;
    step();
    request(1, 0, t0);
    push_exp(1, t0 + 64, 0, 1, 64);
    upto(t0 + 65);
    chk("err_sticky", err, 1);
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("err_clear", err, 0);
    upto(t0 + 75);
    do_reset();
    mode = 2;
    step();
    request(1, 0, t0);
    push_exp(1, t0 + 85, 0, 1, 21);
    upto(t0 + 84);
    clr = 1'b1;
    step();
    clr = 1'b0;
    step();
    chk("err_timeout_wins", err, 1);
    upto(t0 + 95);
    mode = 0;
    do_reset();
    upto(cyc + 6);
    request(1, 0, t0);
    push_exp(0, t0 + 26, 1, 0, 21);
    upto(t0 + 40);
    request(1, 0, t1);
    upto(t1 + 1);
    wdt = 1'b1;
    step();
    wdt = 1'b0;
    upto(t1 + 9);
    srst = 1'b1;
    step();
    srst = 1'b0;
    chk("hold_rst_req", req, 0);
    chk("hold_rst_busy", busy, 0);
    chk("hold_rst_count", cnt, 0);
    chk("hold_rst_err", err, 0);
    upto(t1 + 40);
    chk("hold_rst_pending", busy, 0);
    do_reset();
    step();
    for (int i = 0; i < 5; i++) begin
      request(1, 0, t0);
      push_exp(0, t0 + 26, i < 2 ? i + 1 : 3, 0, 21);
      upto(t0 + 36);
    end
    upto(cyc + 10);
    chk("sb_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/arst_req_ctrl.md
Name: arst_req_ctrl

Overview:
- Initiator side of the reset-request handshake into arst_no.
- Collects software and watchdog reset requests and drives arst_req_o (wired to arst_no arst_req_i) with a guaranteed minimum hold.
- Confirms the handshake by observing the returned arst_n (asserted, then released), with timeouts, error flagging and statistics.
- Lives in the CRG, clocked by the same ref_clk_i as arst_no.

Parameters:
- SYNC_STAGES, 2, flops in the arst_n_i synchroniser (min 2).
- HOLD_CYCLES, 16, min cycles arst_req_o stays high after arst_n is seen low (min 1).
- ACK_TIMEOUT, 64, max cycles to wait for each arst_n edge (min 1).
- COOLDOWN_CYCLES, 8, idle gap after a handshake before a new one may start (min 1).
- CNT_W, 8, width of the completed-request counter.

Ports:
- ref_clk_i  in  1  clock.
- srst_i  in  1  reset; synchronous, active-high, sampled on ref_clk_i rising edge.
- sw_req_i  in  1  software reset request; single-cycle pulse or level, rising edge detected.
- wdt_req_i  in  1  watchdog reset request; rising edge detected.
- clr_err_i  in  1  clears err_o.
- arst_n_i  in  1  arst_n returned from arst_no; asynchronous, synchronised internally.
- arst_req_o  out  1  request to arst_no.
- busy_o  out  1  high in any state except IDLE.
- done_o  out  1  one-cycle pulse when a handshake completes.
- timeout_o  out  1  one-cycle pulse when an ack wait expires.
- err_o  out  1  sticky error, set by any timeout.
- req_count_o  out  CNT_W  completed handshakes, saturating.

Behaviour:
- Reset (srst_i=1 at a clock edge):
  - state=IDLE; arst_req_o=0, busy_o=0, done_o=0, timeout_o=0, err_o=0, req_count_o=0.
  - pending=0, edge-detect history=0, synchroniser flops=1 (released).
  - Applies from any state, including mid-handshake; arst_req_o drops on the next edge.
- Synchroniser: ack_n = arst_n_i delayed SYNC_STAGES flops. Only ack_n is used by the FSM.
- Request event: rising edge of sw_req_i OR wdt_req_i (registered previous-value compare). Both rising in the same cycle counts as one event.
- Pending flag:
  - Set by an event in any state other than IDLE.
  - Only one request is held; further events while pending=1 collapse into it.
- IDLE:
  - Event or pending → ASSERT; arst_req_o=1 from the next edge, so arst_req_o rises 1 cycle after the sw_req_i edge. Clear pending.
  - ack_n low while IDLE (external global reset) is ignored; no state change.
- ASSERT:
  - arst_req_o=1; timer counts cycles in state.
  - ack_n==0 → HOLD, timer cleared.
  - Timer reaches ACK_TIMEOUT-1 with ack_n still 1 → timeout_o pulse, err_o=1, arst_req_o=0, go to COOLDOWN.
- HOLD:
  - arst_req_o=1 for exactly HOLD_CYCLES cycles, then RELEASE.
  - arst_req_o=0 from the first RELEASE cycle.
- RELEASE:
  - arst_req_o=0; timer counts cycles in state.
  - ack_n==1 → done_o pulse (1 cycle), req_count_o+1 (saturates at 2^CNT_W-1, no wrap), go to COOLDOWN.
  - Timer reaches ACK_TIMEOUT-1 with ack_n still 0 → timeout_o pulse, err_o=1, go to COOLDOWN; req_count_o unchanged.
- COOLDOWN:
  - arst_req_o=0 for COOLDOWN_CYCLES cycles, then IDLE.
  - A pending request starts ASSERT on the following cycle via IDLE.
- err_o:
  - Cleared by clr_err_i when no timeout occurs in the same cycle.
  - A simultaneous timeout wins: err_o stays 1.
- done_o and timeout_o are mutually exclusive and never high when state==IDLE.
- arst_req_o is a direct flop output; no glitches.

Test Plan:
- Nominal handshake, model arst_no with 3-cycle assert / 3-cycle release latency:
  - sw_req_i pulse at cycle 10 → arst_req_o=1 at 11.
  - Held 16 cycles after ack_n falls.
  - done_o single pulse; req_count_o=1; busy_o low after 8 cooldown cycles.
- Assert timeout, arst_n_i tied 1: sw_req_i pulse → arst_req_o high 64 cycles, then timeout_o pulse, err_o=1, req_count_o=0. clr_err_i=1 → err_o=0 next cycle.
- Release timeout, arst_n_i stuck 0 after assertion: timeout_o pulse 64 cycles into RELEASE; arst_req_o=0 throughout RELEASE; err_o=1.
- Request collapse:
  - wdt_req_i pulses at cycles 20, 25, 30 during a handshake → exactly one extra handshake after cooldown; req_count_o=2 final.
  - sw_req_i and wdt_req_i rising together → one handshake.
- srst_i asserted for 1 cycle while in HOLD → next cycle: arst_req_o=0, busy_o=0, req_count_o=0, err_o=0, pending=0.
- Saturation with CNT_W=2: 5 nominal handshakes → req_count_o sequence 1, 2, 3, 3, 3.
